// File: rtl/echo_cancel_apply.sv
// Applies the active 4-tap coefficient set to the far-end delay line via a shared FPU.
// Optional FPU watchdog: define ECHO_FPU_WDOG_EN.
module echo_cancel_apply #(
    parameter int FPU_TIMEOUT = 256
) (
    input  logic        clk_operation,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [63:0] signal,
    input  logic [63:0] signal_mic,
    input  logic        para_valid,
    input  logic [63:0] para_0,
    input  logic [63:0] para_1,
    input  logic [63:0] para_2,
    input  logic [63:0] para_3,
    output logic [63:0] out,
    output logic        out_valid,
    output logic        busy,
    output logic        overrun,
    output logic        fpu_timeout,
    output logic        fpu_enable,
    output logic [2:0]  fpu_op,
    output logic [1:0]  fpu_rmode,
    output logic [63:0] fpu_opa,
    output logic [63:0] fpu_opb,
    input  logic [63:0] fpu_out,
    input  logic        fpu_ready
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  idx;
    logic [1:0]  tap;
    logic [63:0] lag  [4];
    logic [63:0] coef [4];
    logic [63:0] pend [4];
    logic [63:0] para [4];
    logic        pend_vld;
    logic [63:0] mic;
    logic [63:0] acc;
    logic [63:0] tmp;
    logic        accept;
    logic        capture;
    logic        abort;
    logic        is_mul;
    logic        is_add;
    logic        is_sub;

    always_comb begin
        para[0] = para_0;
        para[1] = para_1;
        para[2] = para_2;
        para[3] = para_3;
    end

    assign accept    = (state == IDLE) && sample_valid;
    assign capture   = (state == WAIT) && fpu_ready;
    assign busy      = (state != IDLE);
    assign fpu_enable = (state == ISSUE);
    assign fpu_rmode = 2'b00;

    // Op 0 and odd ops below 7 are products; tap index = ceil(idx/2).
    assign is_sub = (idx == 3'd7);
    assign is_mul = (idx == 3'd0) || (idx[0] && !is_sub);
    assign is_add = !is_sub && !is_mul;
    assign tap    = idx[2:1] + {1'b0, idx[0]};

`ifdef ECHO_FPU_WDOG_EN
    localparam int WDW = $clog2(FPU_TIMEOUT + 1);
    logic [WDW-1:0] wd_cnt;
    logic           tmo_q;

    assign abort = (state == WAIT) && !fpu_ready &&
                   (wd_cnt == WDW'(FPU_TIMEOUT - 1));
    assign fpu_timeout = tmo_q;

    always_ff @(posedge clk_operation or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            tmo_q  <= 1'b0;
        end else begin
            tmo_q <= abort;
            if (state == ISSUE)
                wd_cnt <= WDW'(1);
            else if (state == WAIT)
                wd_cnt <= wd_cnt + WDW'(1);
        end
    end
`else
    assign abort       = 1'b0;
    assign fpu_timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (sample_valid) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (fpu_ready)
                    state_nxt = is_sub ? DONE : ISSUE;
                else if (abort)
                    state_nxt = IDLE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fpu_op  = OP_ADD;
        fpu_opa = '0;
        fpu_opb = '0;
        if (state == ISSUE || state == WAIT) begin
            unique case (1'b1)
                is_mul: begin
                    fpu_op  = OP_MUL;
                    fpu_opa = lag[tap];
                    fpu_opb = coef[tap];
                end
                is_add: begin
                    fpu_op  = OP_ADD;
                    fpu_opa = acc;
                    fpu_opb = tmp;
                end
                is_sub: begin
                    fpu_op  = OP_SUB;
                    fpu_opa = mic;
                    fpu_opb = acc;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_operation or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk_operation or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            mic       <= '0;
            acc       <= '0;
            tmp       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            pend_vld  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                lag[i]  <= '0;
                coef[i] <= '0;
                pend[i] <= '0;
            end
        end else begin
            out_valid <= abort;
            overrun   <= sample_valid && busy;
            if (abort)
                out <= mic;
            if (accept) begin
                lag[3] <= lag[2];
                lag[2] <= lag[1];
                lag[1] <= lag[0];
                lag[0] <= signal;
                mic    <= signal_mic;
                idx    <= '0;
            end
            if (capture) begin
                if (is_sub) begin
                    out       <= fpu_out;
                    out_valid <= 1'b1;
                end else if (is_mul && idx != 3'd0) begin
                    tmp <= fpu_out;
                end else begin
                    acc <= fpu_out;
                end
                if (!is_sub)
                    idx <= idx + 3'd1;
            end
            // Sets arriving mid-computation wait until the block is idle again.
            if (state == IDLE) begin
                if (para_valid)
                    coef <= para;
            end else if (state_nxt == IDLE) begin
                if (para_valid)
                    coef <= para;
                else if (pend_vld)
                    coef <= pend;
                pend_vld <= 1'b0;
            end else if (para_valid) begin
                pend     <= para;
                pend_vld <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_echo_cancel_apply.sv
// Bench for echo_cancel_apply: vector table, scoreboard and FPU latency model.
module tb_echo_cancel_apply;

    localparam logic [63:0] D0  = 64'h0000000000000000;
    localparam logic [63:0] D05 = 64'h3FE0000000000000;
    localparam logic [63:0] D1  = 64'h3FF0000000000000;
    localparam logic [63:0] D15 = 64'h3FF8000000000000;
    localparam logic [63:0] D2  = 64'h4000000000000000;
    localparam logic [63:0] D3  = 64'h4008000000000000;
    localparam logic [63:0] M1  = 64'hBFF0000000000000;
    localparam logic [63:0] M25 = 64'hC004000000000000;
    localparam logic [63:0] M3  = 64'hC008000000000000;
    localparam logic [63:0] M4  = 64'hC010000000000000;

    typedef struct {
        logic              rst;
        logic              pv;
        logic [3:0][63:0]  p;
        logic [63:0]       sig;
        logic [63:0]       mic;
        logic [63:0]       exp;
    } vec_t;

    typedef struct {
        logic [63:0] exp;
        int          cyc;
        logic        tmo;
    } sb_t;

    logic        clk_operation = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [63:0] signal = '0;
    logic [63:0] signal_mic = '0;
    logic        para_valid = 1'b0;
    logic [63:0] para_0 = '0;
    logic [63:0] para_1 = '0;
    logic [63:0] para_2 = '0;
    logic [63:0] para_3 = '0;
    logic [63:0] out;
    logic        out_valid;
    logic        busy;
    logic        overrun;
    logic        fpu_timeout;
    logic        fpu_enable;
    logic [2:0]  fpu_op;
    logic [1:0]  fpu_rmode;
    logic [63:0] fpu_opa;
    logic [63:0] fpu_opb;
    logic [63:0] fpu_out = '0;
    logic        fpu_ready = 1'b0;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   lat = 2;
    int   n_out = 0;
    int   n_ovr = 0;
    int   bad_rm = 0;
    bit   fpu_stall = 1'b0;
    sb_t  sb[$];
    vec_t vecs[7];

    echo_cancel_apply #(.FPU_TIMEOUT(16)) dut (
        .clk_operation(clk_operation),
        .rst_n(rst_n),
        .sample_valid(sample_valid),
        .signal(signal),
        .signal_mic(signal_mic),
        .para_valid(para_valid),
        .para_0(para_0),
        .para_1(para_1),
        .para_2(para_2),
        .para_3(para_3),
        .out(out),
        .out_valid(out_valid),
        .busy(busy),
        .overrun(overrun),
        .fpu_timeout(fpu_timeout),
        .fpu_enable(fpu_enable),
        .fpu_op(fpu_op),
        .fpu_rmode(fpu_rmode),
        .fpu_opa(fpu_opa),
        .fpu_opb(fpu_opb),
        .fpu_out(fpu_out),
        .fpu_ready(fpu_ready)
    );

    always #5 clk_operation = ~clk_operation;
    always @(posedge clk_operation) cyc <= cyc + 1;

    function automatic logic [63:0] fcalc(input logic [2:0] op,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
        real x;
        real y;
        x = $bitstoreal(a);
        y = $bitstoreal(b);
        case (op)
            3'b000:  return $realtobits(x + y);
            3'b001:  return $realtobits(x - y);
            3'b010:  return $realtobits(x * y);
            default: return 64'hFFF8_0000_DEAD_BEEF;
        endcase
    endfunction

    // FPU model: result after lat cycles, ready then held one stale extra cycle.
    int fcnt = 0;
    bit fpend = 1'b0;
    int fhold = 0;
    always @(posedge clk_operation) begin
        if (fpu_enable && !fpu_stall) begin
            fpend = 1'b1;
            fcnt  = lat;
            if (fpu_rmode != 2'b00) bad_rm++;
        end
        if (fpend) begin
            fcnt--;
            if (fcnt == 0) begin
                fpend = 1'b0;
                fhold = 1;
                fpu_out   <= fcalc(fpu_op, fpu_opa, fpu_opb);
                fpu_ready <= 1'b1;
            end else begin
                fpu_ready <= 1'b0;
            end
        end else if (fhold > 0) begin
            fhold--;
            fpu_ready <= 1'b1;
        end else begin
            fpu_ready <= 1'b0;
        end
    end

    function automatic void chk(input string nm, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    always @(negedge clk_operation) begin
        sb_t e;
        if (rst_n && overrun) n_ovr++;
        if (rst_n && out_valid) begin
            n_out++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got out %h at cycle %0d expected none",
                         out, cyc);
            end else begin
                e = sb.pop_front();
                chk("out_value", out, e.exp);
                chk("out_cycle", 64'(cyc), 64'(e.cyc));
                chk("timeout_flag", {63'd0, fpu_timeout}, {63'd0, e.tmo});
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        sample_valid = 1'b0;
        para_valid = 1'b0;
        sb.delete();
        #1;
        chk("rst_out", out, D0);
        chk("rst_flags", {58'd0, out_valid, busy, overrun, fpu_timeout,
                          fpu_enable, 1'b0}, 64'd0);
        chk("rst_fpu", fpu_opa | fpu_opb | {59'd0, fpu_op, fpu_rmode}, 64'd0);
        repeat (2) @(posedge clk_operation);
        #1 rst_n = 1'b1;
    endtask

    task automatic accept(input logic [63:0] sig, input logic [63:0] mic,
                          input logic pv, input logic [3:0][63:0] p,
                          output int t);
        @(posedge clk_operation);
        #1;
        if (pv) begin
            para_valid = 1'b1;
            para_0 = p[0];
            para_1 = p[1];
            para_2 = p[2];
            para_3 = p[3];
        end
        sample_valid = 1'b1;
        signal = sig;
        signal_mic = mic;
        t = cyc;
        @(posedge clk_operation);
        #1;
        sample_valid = 1'b0;
        para_valid = 1'b0;
        chk("busy_rise", {63'd0, busy}, 64'd1);
    endtask

    task automatic push(input logic [63:0] exp, input int c, input logic tmo);
        sb_t e;
        e.exp = exp;
        e.cyc = c;
        e.tmo = tmo;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            @(posedge clk_operation);
            #1;
            if (sb.size() == 0) break;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL result_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        chk("busy_fall", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int t;
        int o0;
        int v0;
        logic [3:0][63:0] pz;
        logic [3:0][63:0] ph;
        logic [3:0][63:0] p1;
        logic [3:0][63:0] pa;
        pz = '{D0, D0, D0, D0};
        ph = '{D05, D05, D05, D05};
        p1 = '{D1, D1, D1, D1};
        pa = '{D0, D0, D0, D05};

        vecs[0] = '{rst: 1'b1, pv: 1'b0, p: pz, sig: D1, mic: D2, exp: D2};
        vecs[1] = '{rst: 1'b0, pv: 1'b1, p: pa, sig: D2, mic: D3, exp: D2};
        vecs[2] = '{rst: 1'b1, pv: 1'b1, p: ph, sig: D1, mic: D2, exp: D15};
        vecs[3] = '{rst: 1'b0, pv: 1'b0, p: pz, sig: D1, mic: D2, exp: D1};
        vecs[4] = '{rst: 1'b0, pv: 1'b0, p: pz, sig: D1, mic: D2, exp: D05};
        vecs[5] = '{rst: 1'b0, pv: 1'b0, p: pz, sig: D1, mic: D2, exp: D0};
        vecs[6] = '{rst: 1'b0, pv: 1'b1, p: p1, sig: D3, mic: D3, exp: M3};

        lat = 2;
        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            accept(vecs[i].sig, vecs[i].mic, vecs[i].pv, vecs[i].p, t);
            push(vecs[i].exp, t + 8 * (lat + 1) + 1, 1'b0);
            wait_done();
        end

        // Dropped sample must not shift the delay line.
        lat = 1;
        do_reset();
        o0 = n_out;
        v0 = n_ovr;
        accept(D1, D0, 1'b1, p1, t);
        push(M1, t + 8 * (lat + 1) + 1, 1'b0);
        @(posedge clk_operation);
        @(posedge clk_operation);
        #1;
        sample_valid = 1'b1;
        signal = D3;
        signal_mic = D3;
        @(posedge clk_operation);
        #1;
        sample_valid = 1'b0;
        chk("overrun_pulse", {63'd0, overrun}, 64'd1);
        wait_done();
        chk("overrun_count", 64'(n_ovr - v0), 64'd1);
        chk("out_count", 64'(n_out - o0), 64'd1);
        accept(D2, D0, 1'b0, pz, t);
        push(M3, t + 8 * (lat + 1) + 1, 1'b0);
        wait_done();

        // New set arriving during op 3 applies to the following sample only.
        lat = 3;
        accept(D1, D0, 1'b0, pz, t);
        push(M4, t + 8 * (lat + 1) + 1, 1'b0);
        repeat (3 * (lat + 1) + 1) @(posedge clk_operation);
        #1;
        para_valid = 1'b1;
        para_0 = D05;
        para_1 = D05;
        para_2 = D05;
        para_3 = D05;
        @(posedge clk_operation);
        #1;
        para_valid = 1'b0;
        wait_done();
        accept(D1, D0, 1'b0, pz, t);
        push(M25, t + 8 * (lat + 1) + 1, 1'b0);
        wait_done();

        // Reset mid-computation discards the result.
        lat = 2;
        accept(D1, D2, 1'b0, pz, t);
        repeat (4) @(posedge clk_operation);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_idle", {62'd0, fpu_enable, busy}, 64'd0);
        o0 = n_out;
        repeat (2) @(posedge clk_operation);
        #1 rst_n = 1'b1;
        repeat (60) @(posedge clk_operation);
        chk("midrst_no_out", 64'(n_out - o0), 64'd0);
        accept(D1, D2, 1'b0, pz, t);
        push(D2, t + 8 * (lat + 1) + 1, 1'b0);
        wait_done();

`ifdef ECHO_FPU_WDOG_EN
        fpu_stall = 1'b1;
        accept(D1, D3, 1'b0, pz, t);
        push(D3, t + 1 + 16, 1'b1);
        wait_done();
        fpu_stall = 1'b0;
`endif

        chk("rmode_zero", 64'(bad_rm), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
